// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction field layout,
// FSM state encoding and phase-selection helpers.
package instr_sequencer_pkg;

    localparam int unsigned INSTR_W   = 64;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned ADDR_LSB  = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DATA_LSB  = 11;
    localparam int unsigned RSVD_W    = INSTR_W - DATA_LSB - DATA_W;

    localparam int unsigned WCNT_W    = 7;
    localparam int unsigned OUT_W     = 5;
    localparam int unsigned WAIT_W    = 8;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MAX_WORDS = 64;
    localparam int unsigned MAX_OUT   = 16;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OPC_NOP         = 5'b00000;
    localparam opcode_t OPC_COMPUTE     = 5'b00001;
    localparam opcode_t OPC_COMPUTE_I   = 5'b00010;
    localparam opcode_t OPC_ACC_TO_OBUF = 5'b00011;
    localparam opcode_t OPC_LOAD_INP    = 5'b00100;
    localparam opcode_t OPC_LOAD_WT     = 5'b00101;
    localparam opcode_t OPC_SEND_OBUF   = 5'b00110;
    localparam opcode_t OPC_ACC_RESET   = 5'b00111;
    localparam opcode_t OPC_HALT        = 5'b11111;

    typedef struct packed {
        logic [RSVD_W-1:0] rsvd;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        opcode_t           opcode;
    } instr_t;

    typedef enum logic [3:0] {
        S_IDLE, S_ACC_RST, S_LOAD_WT, S_LOAD_INP, S_COMPUTE,
        S_WAIT, S_DRAIN, S_SEND, S_FIN
    } seq_state_e;

    function automatic logic [WCNT_W-1:0] clamp_words(input logic [WCNT_W-1:0] n);
        return (n > WCNT_W'(MAX_WORDS)) ? WCNT_W'(MAX_WORDS) : n;
    endfunction

    function automatic logic [OUT_W-1:0] clamp_out(input logic [OUT_W-1:0] n);
        return (n > OUT_W'(MAX_OUT)) ? OUT_W'(MAX_OUT) : n;
    endfunction

    // Zero-count phases are skipped by jumping straight to the next populated one.
    function automatic seq_state_e phase_after_acc(input logic [WCNT_W-1:0] n_wt,
                                                   input logic [WCNT_W-1:0] n_inp);
        if (n_wt != '0)  return S_LOAD_WT;
        if (n_inp != '0) return S_LOAD_INP;
        return S_COMPUTE;
    endfunction

    function automatic seq_state_e drain_or_fin(input logic [OUT_W-1:0] n_out);
        return (n_out != '0) ? S_DRAIN : S_FIN;
    endfunction

    function automatic seq_state_e phase_after_compute(input logic [WAIT_W-1:0] n_wait,
                                                       input logic [OUT_W-1:0] n_out);
        return (n_wait != '0) ? S_WAIT : drain_or_fin(n_out);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Pure field packer: places opcode, address and data into a 64-bit instruction word.
module instr_pack
    import instr_sequencer_pkg::*;
(
    input  opcode_t             opcode_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    output instr_t              instr_o
);

    logic [INSTR_W-1:0] word_c;

    always_comb begin
        word_c                        = '0;
        word_c[OPC_LSB  +: OPC_W]     = opcode_i;
        word_c[ADDR_LSB +: ADDR_W]    = addr_i;
        word_c[DATA_LSB +: DATA_W]    = data_i;
    end

    assign instr_o = instr_t'(word_c);

endmodule

// File: rtl/instr_sequencer.sv
// Job-driven instruction sequencer: turns one job request plus an operand stream into a
// registered instruction sequence. Define SEQ_ACC_RESET_EN to issue ACC_RESET at job start.
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [WCNT_W-1:0]   job_n_wt,
    input  logic [WCNT_W-1:0]   job_n_inp,
    input  logic                job_i_mode,
    input  logic [WAIT_W-1:0]   job_wait,
    input  logic [OUT_W-1:0]    job_n_out,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [INSTR_W-1:0]  instruction,
    output logic                busy,
    output logic                done
);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   n_wt_q, n_wt_d, n_inp_q, n_inp_d;
    logic [OUT_W-1:0]    n_out_q, n_out_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                i_mode_q, i_mode_d;
    instr_t              instr_q, instr_d;
    logic                done_q, done_d;

    opcode_t             opc_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   data_c;

    // Next state, counters and the instruction to be registered at the coming edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_wt_d   = n_wt_q;
        n_inp_d  = n_inp_q;
        n_out_d  = n_out_q;
        wait_d   = wait_q;
        i_mode_d = i_mode_q;
        opc_c    = OPC_NOP;
        addr_c   = '0;
        data_c   = '0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    n_wt_d   = clamp_words(job_n_wt);
                    n_inp_d  = clamp_words(job_n_inp);
                    n_out_d  = clamp_out(job_n_out);
                    wait_d   = job_wait;
                    i_mode_d = job_i_mode;
                    cnt_d    = '0;
`ifdef SEQ_ACC_RESET_EN
                    state_d  = S_ACC_RST;
`else
                    state_d  = phase_after_acc(clamp_words(job_n_wt), clamp_words(job_n_inp));
`endif
                end
            end
            S_ACC_RST: begin
`ifdef SEQ_ACC_RESET_EN
                opc_c   = OPC_ACC_RESET;
`endif
                state_d = phase_after_acc(n_wt_q, n_inp_q);
            end
            S_LOAD_WT: begin
                if (s_valid) begin
                    opc_c  = OPC_LOAD_WT;
                    addr_c = cnt_q[ADDR_W-1:0];
                    data_c = s_data;
                    if (cnt_q == CNT_W'(n_wt_q) - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (n_inp_q != '0) ? S_LOAD_INP : S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_INP: begin
                if (s_valid) begin
                    opc_c  = OPC_LOAD_INP;
                    addr_c = cnt_q[ADDR_W-1:0];
                    data_c = s_data;
                    if (cnt_q == CNT_W'(n_inp_q) - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                opc_c   = i_mode_q ? OPC_COMPUTE_I : OPC_COMPUTE;
                cnt_d   = '0;
                state_d = phase_after_compute(wait_q, n_out_q);
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(wait_q) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = drain_or_fin(n_out_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                opc_c  = OPC_ACC_TO_OBUF;
                addr_c = cnt_q[ADDR_W-1:0];
                if (cnt_q == CNT_W'(n_out_q) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                opc_c  = OPC_SEND_OBUF;
                addr_c = cnt_q[ADDR_W-1:0];
                if (cnt_q == CNT_W'(n_out_q) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    instr_pack u_instr_pack (
        .opcode_i (opc_c),
        .addr_i   (addr_c),
        .data_i   (data_c),
        .instr_o  (instr_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_wt_q   <= '0;
            n_inp_q  <= '0;
            n_out_q  <= '0;
            wait_q   <= '0;
            i_mode_q <= 1'b0;
            instr_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_wt_q   <= n_wt_d;
            n_inp_q  <= n_inp_d;
            n_out_q  <= n_out_d;
            wait_q   <= wait_d;
            i_mode_q <= i_mode_d;
            instr_q  <= instr_d;
            done_q   <= done_d;
        end
    end

    assign instruction = instr_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign job_ready   = (state_q == S_IDLE);
    assign s_ready     = (state_q == S_LOAD_WT) || (state_q == S_LOAD_INP);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle expected instructions are queued when a
// job is issued and compared as the DUT produces them. Honours SEQ_ACC_RESET_EN.
module tb_instr_sequencer;

`ifdef SEQ_ACC_RESET_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [6:0]  job_n_wt;
    logic [6:0]  job_n_inp;
    logic        job_i_mode;
    logic [7:0]  job_wait;
    logic [4:0]  job_n_out;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] instruction;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_n_wt    (job_n_wt),
        .job_n_inp   (job_n_inp),
        .job_i_mode  (job_i_mode),
        .job_wait    (job_wait),
        .job_n_out   (job_n_out),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .instruction (instruction),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic        sv;
        logic [31:0] sd;
        logic        sr;
    } cyc_t;

    int          checks   = 0;
    int          failures = 0;
    cyc_t        cyc_q[$];
    logic [64:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input int addr, input logic [31:0] d);
        return {21'b0, d, 6'(addr), op};
    endfunction

    task automatic add(input logic sv, input logic [31:0] sd, input logic sr,
                       input logic [63:0] ins, input logic dn);
        cyc_q.push_back('{sv: sv, sd: sd, sr: sr});
        exp_q.push_back({dn, ins});
    endtask

    // Reference cycle plan for one job, written from the phase ordering of the sequencer.
    task automatic build_job(input int nwt, input int ninp, input bit mode, input int wt,
                             input int nout, input int stall_len);
        int ew = (nwt > 64) ? 64 : nwt;
        int ei = (ninp > 64) ? 64 : ninp;
        int eo = (nout > 16) ? 16 : nout;
        logic [31:0] d;
        if (ACC_EN) add(1'b0, '0, 1'b0, mk(5'h07, 0, '0), 1'b0);
        for (int w = 0; w < ew; w++) begin
            if (w == 1) repeat (stall_len) add(1'b0, '0, 1'b1, 64'd0, 1'b0);
            d = $urandom;
            add(1'b1, d, 1'b1, mk(5'h05, w, d), 1'b0);
        end
        for (int i = 0; i < ei; i++) begin
            d = $urandom;
            add(1'b1, d, 1'b1, mk(5'h04, i, d), 1'b0);
        end
        add(1'b0, '0, 1'b0, mk(mode ? 5'h02 : 5'h01, 0, '0), 1'b0);
        repeat (wt) add(1'b0, '0, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < eo; i++) add(1'b0, '0, 1'b0, mk(5'h03, i, '0), 1'b0);
        for (int i = 0; i < eo; i++) add(1'b0, '0, 1'b0, mk(5'h06, i, '0), 1'b0);
        add(1'b0, '0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic run_job(input string name, input int nwt, input int ninp, input bit mode,
                           input int wt, input int nout, input int stall_len,
                           input int poke_at, input int rst_at);
        int   n;
        bit   aborted = 1'b0;
        cyc_t cy;
        logic [64:0] e;
        build_job(nwt, ninp, mode, wt, nout, stall_len);
        n = cyc_q.size();
        check_val({name, "_ready_pre"}, 64'(job_ready), 64'd1);
        job_valid  = 1'b1;
        job_n_wt   = 7'(nwt);
        job_n_inp  = 7'(ninp);
        job_i_mode = mode;
        job_wait   = 8'(wt);
        job_n_out  = 5'(nout);
        step();
        job_valid  = 1'b0;
        job_n_wt   = 7'($urandom);
        job_n_inp  = 7'($urandom);
        job_wait   = 8'($urandom);
        job_n_out  = 5'($urandom);
        job_i_mode = ~mode;
        check_val({name, "_accept_instr"}, instruction, 64'd0);
        check_val({name, "_accept_busy"}, 64'(busy), 64'd1);
        for (int c = 0; c < n; c++) begin
            cy      = cyc_q.pop_front();
            s_valid = cy.sv;
            s_data  = cy.sv ? cy.sd : 32'($urandom);
            check_val({name, "_s_ready"}, 64'(s_ready), 64'(cy.sr));
            if (c == poke_at) begin
                job_valid = 1'b1;
                job_n_wt  = 7'd9;
                job_n_out = 5'd3;
                check_val({name, "_ready_busy"}, 64'(job_ready), 64'd0);
            end
            if (c == rst_at) rst_n = 1'b0;
            step();
            job_valid = 1'b0;
            s_valid   = 1'b0;
            if (c == rst_at) begin
                rst_n = 1'b1;
                check_val({name, "_rst_instr"}, instruction, 64'd0);
                check_val({name, "_rst_busy"}, 64'(busy), 64'd0);
                check_val({name, "_rst_done"}, 64'(done), 64'd0);
                check_val({name, "_rst_ready"}, 64'(job_ready), 64'd1);
                check_val({name, "_rst_s_ready"}, 64'(s_ready), 64'd0);
                aborted = 1'b1;
                break;
            end
            e = exp_q.pop_front();
            check_val({name, "_instr"}, instruction, e[63:0]);
            check_val({name, "_done"}, 64'(done), 64'(e[64]));
        end
        if (aborted) begin
            cyc_q.delete();
            exp_q.delete();
            repeat (3) begin
                step();
                check_val({name, "_post_rst_instr"}, instruction, 64'd0);
                check_val({name, "_post_rst_done"}, 64'(done), 64'd0);
            end
        end else begin
            check_val({name, "_fin_ready"}, 64'(job_ready), 64'd1);
            check_val({name, "_fin_busy"}, 64'(busy), 64'd0);
            step();
            check_val({name, "_done_pulse_end"}, 64'(done), 64'd0);
            check_val({name, "_idle_instr"}, instruction, 64'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        job_valid  = 1'b0;
        job_n_wt   = '0;
        job_n_inp  = '0;
        job_i_mode = 1'b0;
        job_wait   = '0;
        job_n_out  = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        repeat (2) step();
        check_val("reset_instr", instruction, 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_ready", 64'(job_ready), 64'd1);
        check_val("reset_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        step();
        check_val("idle_instr", instruction, 64'd0);

        run_job("basic",   2,   2, 1'b0, 3,  2, 0, -1, -1);
        run_job("stall",   3,   1, 1'b1, 0,  1, 2, -1, -1);
        run_job("allzero", 0,   0, 1'b1, 0,  0, 0, -1, -1);
        run_job("clamp",   100, 0, 1'b0, 0,  31, 0, -1, -1);
        run_job("clampi",  0,   70, 1'b0, 1, 17, 0, -1, -1);
        run_job("poke",    2,   1, 1'b0, 2,  2, 0, 3, -1);
        run_job("abort",   1,   1, 1'b0, 1,  4, 0, -1, (ACC_EN ? 1 : 0) + 6);
        run_job("after",   2,   2, 1'b0, 3,  2, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
